mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 32 +++
 rtl/mem_lsu.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request, memory-bus and response signals of the load/store unit
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W/8-1:0] bus_sel;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [1:0]        resp_code;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_sel, bus_wdata, resp_valid, resp_data, resp_err, resp_code
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_sel, bus_wdata, resp_valid, resp_data, resp_err, resp_code
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit with big-endian byte lanes and misalignment traps.
// Define LSU_TIMEOUT_EN to abort bus accesses that see no bus_ack within TIMEOUT cycles.
module mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave io,
  output logic     stall_o
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t st, st_n;
  logic we_q, us_q, err_q, breq_q, mis, tmo;
  logic [1:0] sz_q, code_q;
  logic [OW-1:0] off_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [NB-1:0] le, sel, sel_q;
  logic [DATA_W-1:0] wrep, wdata_q, rdata_q, raw, mask, ext;
  logic [2:0] amask;
  logic [7:0] lmask;
  // Lanes are built little-endian then bit-reversed, since byte offset k maps to lane NB-1-k.
  always_comb begin
    amask = 3'((4'd1 << io.req_size) - 4'd1);
    mis = (io.req_size == 2'd3 && DATA_W == 32) || |(io.req_addr[2:0] & amask);
    lmask = 8'((9'd1 << (4'd1 << io.req_size)) - 9'd1);
    le = NB'(lmask) << io.req_addr[OW-1:0];
    sel = {<<{le}};
    wrep = io.req_wdata & ~({DATA_W{1'b1}} << (8 << io.req_size));
    for (int s = 8; s < DATA_W; s = s * 2)
      wrep = s >= (8 << io.req_size) ? wrep | (wrep << s) : wrep;
    raw = io.bus_rdata >> (DATA_W - 8 * int'(off_q) - (8 << sz_q));
    mask = ~({DATA_W{1'b1}} << (8 << sz_q));
    ext = (!us_q && |(raw & mask & ~(mask >> 1))) ? raw | ~mask : raw & mask;
  end
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= st == BUS ? cnt + CW'(1) : '0;
  assign tmo = st == BUS && !io.bus_ack && cnt == CW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    st_n = st;
    if (st == IDLE) st_n = io.req_valid ? (mis ? RESP : BUS) : IDLE;
    else if (st == BUS) st_n = (io.bus_ack || tmo) ? RESP : BUS;
    else st_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      we_q <= 1'b0;
      us_q <= 1'b0;
      sz_q <= 2'd0;
      off_q <= '0;
      err_q <= 1'b0;
      code_q <= 2'd0;
      breq_q <= 1'b0;
      baddr_q <= '0;
      sel_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && io.req_valid) begin
        we_q <= io.req_we;
        us_q <= io.req_unsigned;
        sz_q <= io.req_size;
        off_q <= io.req_addr[OW-1:0];
        err_q <= mis;
        code_q <= mis ? (io.req_we ? 2'd2 : 2'd1) : 2'd0;
        breq_q <= !mis;
        baddr_q <= {io.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        sel_q <= sel;
        wdata_q <= wrep;
        rdata_q <= '0;
      end
      if (st == BUS && (io.bus_ack || tmo)) begin
        breq_q <= 1'b0;
        if (io.bus_ack) rdata_q <= we_q ? '0 : ext;
        else begin
          err_q <= 1'b1;
          code_q <= 2'd3;
        end
      end
    end
  assign io.req_ready = rst && st == IDLE;
  assign io.bus_req = breq_q;
  assign io.bus_we = breq_q && we_q;
  assign io.bus_addr = breq_q ? baddr_q : '0;
  assign io.bus_sel = breq_q ? sel_q : '0;
  assign io.bus_wdata = breq_q ? wdata_q : '0;
  assign io.resp_valid = st == RESP;
  assign io.resp_data = st == RESP ? rdata_q : '0;
  assign io.resp_err = st == RESP && err_q;
  assign io.resp_code = st == RESP ? code_q : 2'd0;
  assign stall_o = st != IDLE;
endmodule
